// File: rtl/interrupt_arbiter_pkg.sv
// Shared constants for the interrupt arbiter: default vector addresses and
// the encoding of the arbiter state register.
package interrupt_arbiter_pkg;

    localparam int          NUM_IRQ          = 14;
    localparam logic [3:0]  NMI_INDEX        = 4'd14;

    localparam logic [15:0] VEC_BASE_DEFAULT = 16'hFFE0;
    localparam logic [15:0] VEC_NMI_DEFAULT  = 16'hFFFC;

    localparam logic [1:0]  ST_IDLE          = 2'd0;
    localparam logic [1:0]  ST_REQ           = 2'd1;
    localparam logic [1:0]  ST_ACK           = 2'd2;

endpackage

// File: rtl/interrupt_arbiter_prio_enc14.sv
// Combinational 15-input priority encoder; the highest set bit wins and its
// index is returned together with a valid flag.
module prio_enc14 (
    input  logic [14:0] req_i,
    output logic        valid_o,
    output logic [3:0]  index_o
);

    // Ascending scan so that the highest set bit overwrites lower ones.
    always_comb begin
        valid_o = |req_i;
        index_o = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (req_i[i]) begin
                index_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: picks the highest pending source, presents a registered
// request and vector to the CPU and pulses a one-hot accept on acknowledge.
module interrupt_arbiter
    import interrupt_arbiter_pkg::*;
#(
    parameter logic [15:0] VEC_BASE = VEC_BASE_DEFAULT,
    parameter logic [15:0] VEC_NMI  = VEC_NMI_DEFAULT
) (
    input  logic        MCLK,
    input  logic        reset,
    input  logic [13:0] IRQ,
    input  logic        NMI,
    input  logic        GIE,
    input  logic        INTACK,
    output logic        INT,
    output logic [14:0] IRQACC,
    output logic [15:0] INTADDR
);

    logic [1:0]  state_q,   state_d;
    logic        nmiQ_q;
    logic        nmiPend_q, nmiPend_d;
    logic        intReq_q,  intReq_d;
    logic [15:0] intAddr_q, intAddr_d;
    logic [14:0] irqAcc_q,  irqAcc_d;
    logic [3:0]  srcIdx_q,  srcIdx_d;

    logic [14:0] eff;
    logic        effValid;
    logic [3:0]  effIdx;
    logic [15:0] vecSel;
    logic        nmiEdge;
    logic        nmiClr;

    assign eff     = {nmiPend_q, IRQ & {NUM_IRQ{GIE}}};
    assign nmiEdge = NMI & ~nmiQ_q;

    prio_enc14 uPrioEnc (
        .req_i   (eff),
        .valid_o (effValid),
        .index_o (effIdx)
    );

    assign vecSel = (effIdx == NMI_INDEX) ? VEC_NMI
                                          : VEC_BASE + {11'd0, effIdx, 1'b0};

    // srcIdx_q remembers which source the presented vector belongs to, so the
    // accept pulse always matches what the CPU is actually fetching.
    always_comb begin
        state_d   = state_q;
        intReq_d  = 1'b0;
        intAddr_d = 16'h0000;
        irqAcc_d  = 15'd0;
        srcIdx_d  = srcIdx_q;
        nmiClr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (effValid) begin
                    state_d   = ST_REQ;
                    intReq_d  = 1'b1;
                    intAddr_d = vecSel;
                    srcIdx_d  = effIdx;
                end
            end
            ST_REQ: begin
                if (INTACK) begin
                    state_d  = ST_ACK;
                    irqAcc_d = 15'd1 << srcIdx_q;
                    nmiClr   = (intAddr_q == VEC_NMI);
                end else if (effValid) begin
                    intReq_d  = 1'b1;
                    intAddr_d = vecSel;
                    srcIdx_d  = effIdx;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A fresh NMI edge beats a simultaneous acknowledge clear.
    always_comb begin
        nmiPend_d = nmiPend_q;
        if (nmiClr) begin
            nmiPend_d = 1'b0;
        end
        if (nmiEdge) begin
            nmiPend_d = 1'b1;
        end
    end

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            nmiQ_q    <= 1'b0;
            nmiPend_q <= 1'b0;
            intReq_q  <= 1'b0;
            intAddr_q <= 16'h0000;
            irqAcc_q  <= 15'd0;
            srcIdx_q  <= 4'd0;
        end else begin
            state_q   <= state_d;
            nmiQ_q    <= NMI;
            nmiPend_q <= nmiPend_d;
            intReq_q  <= intReq_d;
            intAddr_q <= intAddr_d;
            irqAcc_q  <= irqAcc_d;
            srcIdx_q  <= srcIdx_d;
        end
    end

    assign INT     = intReq_q;
    assign INTADDR = intAddr_q;
    assign IRQACC  = irqAcc_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Scoreboard bench for interrupt_arbiter: directed steps queue the expected
// output changes, a negedge monitor pops one entry per observed change.
module tb_interrupt_arbiter;

    logic        MCLK   = 1'b0;
    logic        reset  = 1'b1;
    logic [13:0] IRQ    = 14'h0000;
    logic        NMI    = 1'b0;
    logic        GIE    = 1'b0;
    logic        INTACK = 1'b0;
    logic        INT;
    logic [15:0] INTADDR;
    logic [14:0] IRQACC;

    int cycleCount  = 0;
    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        int          cyc;
        logic        intV;
        logic [15:0] addr;
        logic [14:0] acc;
        string       name;
    } expT;

    expT         sbq[$];
    logic [31:0] lastSnap = 32'h0;

    interrupt_arbiter #(
        .VEC_BASE (16'hFFE0),
        .VEC_NMI  (16'hFFFC)
    ) dut (
        .MCLK    (MCLK),
        .reset   (reset),
        .IRQ     (IRQ),
        .NMI     (NMI),
        .GIE     (GIE),
        .INTACK  (INTACK),
        .INT     (INT),
        .INTADDR (INTADDR),
        .IRQACC  (IRQACC)
    );

    always #5 MCLK = ~MCLK;

    always @(posedge MCLK) cycleCount <= cycleCount + 1;

    task automatic applyStimulus(input logic [13:0] irq, input logic gie,
                                 input logic nmi, input logic intack);
        @(posedge MCLK);
        #1;
        IRQ    = irq;
        GIE    = gie;
        NMI    = nmi;
        INTACK = intack;
    endtask

    task automatic expectIn(input int k, input logic intV, input logic [15:0] addr,
                            input logic [14:0] acc, input string name);
        expT e;
        e.cyc  = cycleCount + k;
        e.intV = intV;
        e.addr = addr;
        e.acc  = acc;
        e.name = name;
        sbq.push_back(e);
    endtask

    task automatic checkOutput();
        expT e;
        testsRun++;
        if (sbq.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL unexpected_change: got INT=%0b INTADDR=%h IRQACC=%h at cycle %0d, required no change",
                     INT, INTADDR, IRQACC, cycleCount);
        end else begin
            e = sbq.pop_front();
            if (cycleCount != e.cyc || INT !== e.intV || INTADDR !== e.addr || IRQACC !== e.acc) begin
                testsFailed++;
                $display("[TB] FAIL %s: got cycle %0d INT=%0b INTADDR=%h IRQACC=%h, required cycle %0d INT=%0b INTADDR=%h IRQACC=%h",
                         e.name, cycleCount, INT, INTADDR, IRQACC, e.cyc, e.intV, e.addr, e.acc);
            end
        end
    endtask

    task automatic checkNow(input string name);
        testsRun++;
        if (INT !== 1'b0 || INTADDR !== 16'h0000 || IRQACC !== 15'd0) begin
            testsFailed++;
            $display("[TB] FAIL %s: got INT=%0b INTADDR=%h IRQACC=%h, required all zero",
                     name, INT, INTADDR, IRQACC);
        end
    endtask

    // Any output change outside reset must correspond to the next queued entry.
    always @(negedge MCLK) begin
        if (reset) begin
            lastSnap = {INT, INTADDR, IRQACC};
        end else if ({INT, INTADDR, IRQACC} !== lastSnap) begin
            checkOutput();
            lastSnap = {INT, INTADDR, IRQACC};
        end
    end

    initial begin
        expT e;
        applyStimulus(14'h0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(14'h0000, 1'b0, 1'b0, 1'b0);
        checkNow("reset_state");
        reset = 1'b0;

        // Lowest source request, acknowledge and return to idle.
        applyStimulus(14'h0001, 1'b1, 1'b0, 1'b0); expectIn(1, 1'b1, 16'hFFE0, 15'h0000, "irq0_req");
        applyStimulus(14'h0001, 1'b1, 1'b0, 1'b1); expectIn(1, 1'b0, 16'h0000, 15'h0001, "irq0_ack");
        applyStimulus(14'h0000, 1'b1, 1'b0, 0);    expectIn(1, 1'b0, 16'h0000, 15'h0000, "irq0_idle");
        applyStimulus(14'h0000, 1'b1, 1'b0, 1'b0);

        // Priority and re-evaluation before acknowledge.
        applyStimulus(14'h2004, 1'b1, 1'b0, 1'b0); expectIn(1, 1'b1, 16'hFFFA, 15'h0000, "prio_bit13");
        applyStimulus(14'h0004, 1'b1, 1'b0, 1'b0); expectIn(1, 1'b1, 16'hFFE4, 15'h0000, "reeval_bit2");
        applyStimulus(14'h0004, 1'b1, 1'b0, 1'b1); expectIn(1, 1'b0, 16'h0000, 15'h0004, "bit2_ack");
        applyStimulus(14'h0000, 1'b1, 1'b0, 1'b0); expectIn(1, 1'b0, 16'h0000, 15'h0000, "bit2_idle");
        applyStimulus(14'h0000, 1'b1, 1'b0, 1'b0);

        // GIE low masks everything but the NMI, which takes one extra cycle.
        repeat (3) applyStimulus(14'h3FFF, 1'b0, 1'b0, 1'b0);
        applyStimulus(14'h3FFF, 1'b0, 1'b1, 1'b0); expectIn(2, 1'b1, 16'hFFFC, 15'h0000, "nmi_req");
        applyStimulus(14'h3FFF, 1'b0, 1'b0, 1'b0);
        applyStimulus(14'h3FFF, 1'b0, 1'b0, 1'b1); expectIn(1, 1'b0, 16'h0000, 15'h4000, "nmi_ack");
        applyStimulus(14'h3FFF, 1'b0, 1'b0, 1'b0); expectIn(1, 1'b0, 16'h0000, 15'h0000, "nmi_idle");
        repeat (3) applyStimulus(14'h3FFF, 1'b0, 1'b0, 1'b0);

        // NMI edge landing on the NMI acknowledge keeps the request pending.
        applyStimulus(14'h0000, 1'b0, 1'b1, 1'b0); expectIn(2, 1'b1, 16'hFFFC, 15'h0000, "nmi2_req");
        applyStimulus(14'h0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(14'h0000, 1'b0, 1'b1, 1'b1); expectIn(1, 1'b0, 16'h0000, 15'h4000, "nmi2_ack");
        applyStimulus(14'h0000, 1'b0, 1'b0, 1'b0);
        expectIn(1, 1'b0, 16'h0000, 15'h0000, "nmi2_idle");
        expectIn(2, 1'b1, 16'hFFFC, 15'h0000, "nmi_set_wins_req");
        applyStimulus(14'h0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(14'h0000, 1'b0, 1'b0, 1'b1); expectIn(1, 1'b0, 16'h0000, 15'h4000, "nmi3_ack");
        applyStimulus(14'h0000, 1'b0, 1'b0, 1'b0); expectIn(1, 1'b0, 16'h0000, 15'h0000, "nmi3_idle");
        repeat (2) applyStimulus(14'h0000, 1'b0, 1'b0, 1'b0);

        // Dropping GIE while requesting withdraws without an accept pulse.
        applyStimulus(14'h0010, 1'b1, 1'b0, 1'b0); expectIn(1, 1'b1, 16'hFFE8, 15'h0000, "bit4_req");
        applyStimulus(14'h0010, 1'b0, 1'b0, 1'b0); expectIn(1, 1'b0, 16'h0000, 15'h0000, "gie_drop");
        repeat (2) applyStimulus(14'h0000, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges while requesting.
        applyStimulus(14'h0002, 1'b1, 1'b0, 1'b0); expectIn(1, 1'b1, 16'hFFE2, 15'h0000, "bit1_req");
        applyStimulus(14'h0002, 1'b1, 1'b0, 1'b0);
        @(negedge MCLK);
        #2 reset = 1'b1;
        #1 checkNow("async_reset");
        applyStimulus(14'h0002, 1'b1, 1'b0, 1'b0);
        applyStimulus(14'h0002, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;                              expectIn(1, 1'b1, 16'hFFE2, 15'h0000, "post_reset_req");
        applyStimulus(14'h0000, 1'b1, 1'b0, 1'b0); expectIn(1, 1'b0, 16'h0000, 15'h0000, "post_reset_idle");
        repeat (2) applyStimulus(14'h0000, 1'b1, 1'b0, 1'b0);

        // Held request with INTACK held high: INT 1,0,0,1 then withdraw.
        applyStimulus(14'h0001, 1'b1, 1'b0, 1'b0); expectIn(1, 1'b1, 16'hFFE0, 15'h0000, "gap_req1");
        applyStimulus(14'h0001, 1'b1, 1'b0, 1'b1); expectIn(1, 1'b0, 16'h0000, 15'h0001, "gap_ack");
        applyStimulus(14'h0001, 1'b1, 1'b0, 1'b1); expectIn(1, 1'b0, 16'h0000, 15'h0000, "gap_idle");
        applyStimulus(14'h0001, 1'b1, 1'b0, 1'b1); expectIn(1, 1'b1, 16'hFFE0, 15'h0000, "gap_req2");
        applyStimulus(14'h0000, 1'b1, 1'b0, 1'b0); expectIn(1, 1'b0, 16'h0000, 15'h0000, "withdraw");
        repeat (4) applyStimulus(14'h0000, 1'b1, 1'b0, 1'b0);

        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s: got no output change, required change at cycle %0d", e.name, e.cyc);
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
